// File: rtl/alu_pipe_top.sv
// alu_pipe_top: three-stage (EX / MEM / WB) execute pipeline with a register
// file, operand forwarding, a one-cycle load-use stall, word-addressed data
// memory and a registered branch-equality flag.
//
// Handshake: an instruction is taken into EX on a rising clk edge where
// in_valid && in_ready. in_ready is a function of pipeline state only (the
// load-use stall) and never looks at in_valid; with in_valid low a bubble
// enters EX.
module alu_pipe_top #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CONTROL_WIDTH  = 3,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int A0_INDEX       = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [REG_ADDR_WIDTH-1:0] rs1,
    input  logic [REG_ADDR_WIDTH-1:0] rs2,
    input  logic [REG_ADDR_WIDTH-1:0] rd,
    input  logic [DATA_WIDTH-1:0]     ImmOp,
    input  logic                      ALUsrc,
    input  logic [CONTROL_WIDTH-1:0]  ALUctrl,
    input  logic                      RegWrite,
    input  logic                      MemWrite,
    input  logic                      MemRead,
    output logic [DATA_WIDTH-1:0]     a0,
    output logic                      EQ,
    output logic                      EQ_valid
);

    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;
    localparam int MEM_WORDS = 2 ** MEM_ADDR_WIDTH;
    localparam int SHAMT_W = $clog2(DATA_WIDTH);
    localparam logic [REG_ADDR_WIDTH-1:0] A0_IDX = REG_ADDR_WIDTH'(A0_INDEX);

    localparam logic [CONTROL_WIDTH-1:0] OP_ADD = CONTROL_WIDTH'(0);
    localparam logic [CONTROL_WIDTH-1:0] OP_SUB = CONTROL_WIDTH'(1);
    localparam logic [CONTROL_WIDTH-1:0] OP_AND = CONTROL_WIDTH'(2);
    localparam logic [CONTROL_WIDTH-1:0] OP_OR  = CONTROL_WIDTH'(3);
    localparam logic [CONTROL_WIDTH-1:0] OP_XOR = CONTROL_WIDTH'(4);
    localparam logic [CONTROL_WIDTH-1:0] OP_SLT = CONTROL_WIDTH'(5);
    localparam logic [CONTROL_WIDTH-1:0] OP_SLL = CONTROL_WIDTH'(6);
    localparam logic [CONTROL_WIDTH-1:0] OP_SRL = CONTROL_WIDTH'(7);

    // Architectural state
    logic [DATA_WIDTH-1:0]     r_rf   [NUM_REGS];
    logic [DATA_WIDTH-1:0]     r_dmem [MEM_WORDS];

    // EX stage register
    logic                      r_ex_valid;
    logic [REG_ADDR_WIDTH-1:0] r_ex_rs1;
    logic [REG_ADDR_WIDTH-1:0] r_ex_rs2;
    logic [REG_ADDR_WIDTH-1:0] r_ex_rd;
    logic [DATA_WIDTH-1:0]     r_ex_imm;
    logic                      r_ex_alusrc;
    logic [CONTROL_WIDTH-1:0]  r_ex_ctrl;
    logic                      r_ex_regwrite;
    logic                      r_ex_memwrite;
    logic                      r_ex_memread;

    // MEM stage register
    logic                      r_mem_valid;
    logic [REG_ADDR_WIDTH-1:0] r_mem_rd;
    logic [DATA_WIDTH-1:0]     r_mem_alu;
    logic [DATA_WIDTH-1:0]     r_mem_store;
    logic                      r_mem_regwrite;
    logic                      r_mem_memwrite;
    logic                      r_mem_memread;

    // WB stage register
    logic                      r_wb_valid;
    logic [REG_ADDR_WIDTH-1:0] r_wb_rd;
    logic [DATA_WIDTH-1:0]     r_wb_alu;
    logic [DATA_WIDTH-1:0]     r_wb_rdata;
    logic                      r_wb_regwrite;
    logic                      r_wb_memread;

    // Branch-equality flag
    logic                      r_eq;
    logic                      r_eq_valid;

    // Combinational datapath
    logic                      w_mem_fwd_ok;
    logic                      w_wb_fwd_ok;
    logic [DATA_WIDTH-1:0]     w_wb_result;
    logic [DATA_WIDTH-1:0]     w_op1;
    logic [DATA_WIDTH-1:0]     w_rs2_val;
    logic [DATA_WIDTH-1:0]     w_op2;
    logic [DATA_WIDTH-1:0]     w_alu_out;
    logic                      w_stall;
    logic                      w_advance;
    logic [MEM_ADDR_WIDTH-1:0] w_mem_addr;

    assign w_wb_result = r_wb_memread ? r_wb_rdata : r_wb_alu;
    assign w_mem_addr  = r_mem_alu[MEM_ADDR_WIDTH+1:2];

    // Load-use hazard: the loaded word is not available until WB, so the
    // consumer waits one cycle in EX and then takes it from the WB path.
    // rs2 only counts as a source when it feeds the ALU or is store data.
    assign w_stall = r_ex_valid && r_mem_valid && r_mem_memread && (r_mem_rd != '0) &&
                     ((r_ex_rs1 == r_mem_rd) ||
                      ((r_ex_rs2 == r_mem_rd) && (!r_ex_alusrc || r_ex_memwrite)));
    assign w_advance = r_ex_valid && !w_stall;
    assign in_ready  = !w_stall;

    assign a0       = r_rf[A0_IDX];
    assign EQ       = r_eq;
    assign EQ_valid = r_eq_valid;

    // Operand select for EX: youngest producer wins (MEM, then WB, then RF).
    // The WB path also covers a same-cycle RF write of the register being read.
    always_comb begin
        w_mem_fwd_ok = r_mem_valid && r_mem_regwrite && (r_mem_rd != '0);
        w_wb_fwd_ok  = r_wb_valid && r_wb_regwrite && (r_wb_rd != '0);
        w_op1        = r_rf[r_ex_rs1];
        w_rs2_val    = r_rf[r_ex_rs2];
        if (w_mem_fwd_ok && (r_mem_rd == r_ex_rs1)) begin
            w_op1 = r_mem_alu;
        end else if (w_wb_fwd_ok && (r_wb_rd == r_ex_rs1)) begin
            w_op1 = w_wb_result;
        end
        if (w_mem_fwd_ok && (r_mem_rd == r_ex_rs2)) begin
            w_rs2_val = r_mem_alu;
        end else if (w_wb_fwd_ok && (r_wb_rd == r_ex_rs2)) begin
            w_rs2_val = w_wb_result;
        end
        w_op2 = r_ex_alusrc ? r_ex_imm : w_rs2_val;
    end

    // ALU; all arithmetic wraps at DATA_WIDTH bits.
    always_comb begin
        w_alu_out = '0;
        case (r_ex_ctrl)
            OP_ADD:  w_alu_out = w_op1 + w_op2;
            OP_SUB:  w_alu_out = w_op1 - w_op2;
            OP_AND:  w_alu_out = w_op1 & w_op2;
            OP_OR:   w_alu_out = w_op1 | w_op2;
            OP_XOR:  w_alu_out = w_op1 ^ w_op2;
            OP_SLT:  w_alu_out = {{(DATA_WIDTH-1){1'b0}}, ($signed(w_op1) < $signed(w_op2))};
            OP_SLL:  w_alu_out = w_op1 << w_op2[SHAMT_W-1:0];
            OP_SRL:  w_alu_out = w_op1 >> w_op2[SHAMT_W-1:0];
            default: w_alu_out = '0;
        endcase
    end

    // EX register: load a new instruction (or bubble) unless stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_valid    <= 1'b0;
            r_ex_rs1      <= '0;
            r_ex_rs2      <= '0;
            r_ex_rd       <= '0;
            r_ex_imm      <= '0;
            r_ex_alusrc   <= 1'b0;
            r_ex_ctrl     <= '0;
            r_ex_regwrite <= 1'b0;
            r_ex_memwrite <= 1'b0;
            r_ex_memread  <= 1'b0;
        end else if (!w_stall) begin
            r_ex_valid    <= in_valid;
            r_ex_rs1      <= rs1;
            r_ex_rs2      <= rs2;
            r_ex_rd       <= rd;
            r_ex_imm      <= ImmOp;
            r_ex_alusrc   <= ALUsrc;
            r_ex_ctrl     <= ALUctrl;
            r_ex_regwrite <= RegWrite;
            r_ex_memwrite <= MemWrite;
            r_ex_memread  <= MemRead;
        end
    end

    // MEM register: takes the EX result, or a bubble while EX is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_valid    <= 1'b0;
            r_mem_rd       <= '0;
            r_mem_alu      <= '0;
            r_mem_store    <= '0;
            r_mem_regwrite <= 1'b0;
            r_mem_memwrite <= 1'b0;
            r_mem_memread  <= 1'b0;
        end else begin
            r_mem_valid    <= w_advance;
            r_mem_rd       <= r_ex_rd;
            r_mem_alu      <= w_alu_out;
            r_mem_store    <= w_rs2_val;
            r_mem_regwrite <= r_ex_regwrite;
            r_mem_memwrite <= r_ex_memwrite;
            r_mem_memread  <= r_ex_memread;
        end
    end

    // Branch-equality flag: pulses valid once per instruction leaving EX, value held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_eq       <= 1'b0;
            r_eq_valid <= 1'b0;
        end else begin
            r_eq_valid <= w_advance;
            if (w_advance) begin
                r_eq <= (w_op1 == w_op2);
            end
        end
    end

    // WB register, including the synchronous data-memory read for loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid    <= 1'b0;
            r_wb_rd       <= '0;
            r_wb_alu      <= '0;
            r_wb_rdata    <= '0;
            r_wb_regwrite <= 1'b0;
            r_wb_memread  <= 1'b0;
        end else begin
            r_wb_valid    <= r_mem_valid;
            r_wb_rd       <= r_mem_rd;
            r_wb_alu      <= r_mem_alu;
            r_wb_regwrite <= r_mem_regwrite;
            r_wb_memread  <= r_mem_memread;
            if (r_mem_valid && r_mem_memread) begin
                r_wb_rdata <= r_dmem[w_mem_addr];
            end
        end
    end

    // Register file write at the end of WB; register 0 is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_rf[i] <= '0;
            end
        end else if (r_wb_valid && r_wb_regwrite && (r_wb_rd != '0)) begin
            r_rf[r_wb_rd] <= w_wb_result;
        end
    end

    // Data memory write port; contents survive reset, and reset clears
    // r_mem_valid asynchronously so no store lands on or after the reset edge.
    always_ff @(posedge clk) begin
        if (r_mem_valid && r_mem_memwrite) begin
            r_dmem[w_mem_addr] <= r_mem_store;
        end
    end

endmodule

// File: tb/tb_alu_pipe_top.sv
// Bench for alu_pipe_top: directed scenarios followed by random instruction
// streams, checked every cycle against an in-order instruction-level model.
module tb_alu_pipe_top;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 3;
    localparam int MW = 10;

    // ---------------- clock / reset / DUT ----------------
    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [RW-1:0] rs1      = '0;
    logic [RW-1:0] rs2      = '0;
    logic [RW-1:0] rd       = '0;
    logic [DW-1:0] ImmOp    = '0;
    logic          ALUsrc   = 1'b0;
    logic [CW-1:0] ALUctrl  = '0;
    logic          RegWrite = 1'b0;
    logic          MemWrite = 1'b0;
    logic          MemRead  = 1'b0;
    logic [DW-1:0] a0;
    logic          EQ;
    logic          EQ_valid;

    always #5 clk = ~clk;

    alu_pipe_top #(
        .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .CONTROL_WIDTH(CW),
        .MEM_ADDR_WIDTH(MW), .A0_INDEX(10)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .rd(rd), .ImmOp(ImmOp), .ALUsrc(ALUsrc),
        .ALUctrl(ALUctrl), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .MemRead(MemRead), .a0(a0), .EQ(EQ), .EQ_valid(EQ_valid)
    );

    // ---------------- instruction-level reference model ----------------
    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        alusrc;
        logic [2:0]  ctrl;
        logic        regwrite;
        logic        memwrite;
        logic        memread;
    } instr_t;

    typedef struct { int due; logic [31:0] val; } a0_ev_t;
    typedef struct { int due; logic val; } eq_ev_t;
    typedef struct { int due; int addr; logic [31:0] data; } st_ev_t;

    logic [31:0] regs [32];
    logic [31:0] mem_m [int];   // memory as seen by the program order
    logic [31:0] mem_c [int];   // memory actually committed by now
    a0_ev_t      a0_q [$];
    eq_ev_t      eq_q [$];
    st_ev_t      st_q [$];
    logic [31:0] exp_a0;
    instr_t      prev;
    bit          prev_valid;
    int          prev_leave;
    bit          stall_pend;
    int          stall_edge;

    int edge_cnt;
    int tests;
    int fails;
    int eq_pulses;
    int ready_low_cnt;
    int last_eq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6:    return a << b[4:0];
            default: return a >> b[4:0];
        endcase
    endfunction

    function automatic bit ready_exp();
        return !(stall_pend && (stall_edge == edge_cnt));
    endfunction

    // Execute one instruction in program order; record when its effects
    // must become visible given that it enters EX at edge acc.
    task automatic model_accept(input instr_t ins, input int acc);
        bit          in_mem;
        bit          st;
        int          s;
        int          addr;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] res;
        logic [31:0] wbv;
        in_mem = prev_valid && (prev_leave == acc);
        st = in_mem && prev.memread && (prev.rd != 5'd0) &&
             ((ins.rs1 == prev.rd) || ((ins.rs2 == prev.rd) && (!ins.alusrc || ins.memwrite)));
        s = st ? 1 : 0;
        op1 = regs[ins.rs1];
        op2 = ins.alusrc ? ins.imm : regs[ins.rs2];
        res = ref_alu(ins.ctrl, op1, op2);
        addr = int'(res[11:2]);
        eq_q.push_back('{due: acc + 1 + s, val: (op1 == op2)});
        if (ins.memwrite) begin
            mem_m[addr] = regs[ins.rs2];
            st_q.push_back('{due: acc + 2 + s, addr: addr, data: regs[ins.rs2]});
        end
        wbv = res;
        if (ins.memread) wbv = mem_m.exists(addr) ? mem_m[addr] : 32'd0;
        if (ins.regwrite && (ins.rd != 5'd0)) regs[ins.rd] = wbv;
        a0_q.push_back('{due: acc + 3 + s, val: regs[10]});
        if (st) begin
            stall_pend = 1'b1;
            stall_edge = acc;
        end
        prev       = ins;
        prev_valid = 1'b1;
        prev_leave = acc + 1 + s;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) regs[i] = '0;
        mem_m = mem_c;
        a0_q.delete();
        eq_q.delete();
        st_q.delete();
        exp_a0     = '0;
        prev_valid = 1'b0;
        stall_pend = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        edge_cnt++;
        #1;
        while (st_q.size() > 0 && st_q[0].due <= edge_cnt) begin
            mem_c[st_q[0].addr] = st_q[0].data;
            void'(st_q.pop_front());
        end
        while (a0_q.size() > 0 && a0_q[0].due <= edge_cnt) begin
            exp_a0 = a0_q[0].val;
            void'(a0_q.pop_front());
        end
        chk("a0", a0, exp_a0);
        if (eq_q.size() > 0 && eq_q[0].due == edge_cnt) begin
            chk("eq_valid", {31'd0, EQ_valid}, 32'd1);
            chk("eq", {31'd0, EQ}, {31'd0, eq_q[0].val});
            last_eq = int'(EQ);
            eq_pulses++;
            void'(eq_q.pop_front());
        end else begin
            chk("eq_valid_idle", {31'd0, EQ_valid}, 32'd0);
        end
        chk("in_ready", {31'd0, in_ready}, {31'd0, ready_exp()});
        if (!in_ready) ready_low_cnt++;
    endtask

    task automatic drive(input instr_t ins, input logic v);
        in_valid = v;
        rs1      = ins.rs1;
        rs2      = ins.rs2;
        rd       = ins.rd;
        ImmOp    = ins.imm;
        ALUsrc   = ins.alusrc;
        ALUctrl  = ins.ctrl;
        RegWrite = ins.regwrite;
        MemWrite = ins.memwrite;
        MemRead  = ins.memread;
    endtask

    task automatic issue(input instr_t ins);
        bit done;
        done = 1'b0;
        for (int t = 0; t < 4 && !done; t++) begin
            drive(ins, 1'b1);
            if (ready_exp()) begin
                model_accept(ins, edge_cnt + 1);
                done = 1'b1;
            end
            tick();
        end
        if (!done) chk("issue_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input int n, input instr_t junk);
        drive(junk, 1'b1);
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            edge_cnt++;
            #1;
            chk("rst_a0", a0, 32'd0);
            chk("rst_eq", {31'd0, EQ}, 32'd0);
            chk("rst_eq_valid", {31'd0, EQ_valid}, 32'd0);
            chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
    endtask

    // ---------------- instruction builders ----------------
    function automatic instr_t mk(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                                  input logic [31:0] imm, input logic src, input logic [2:0] op,
                                  input logic rw, input logic mw, input logic mr);
        instr_t t;
        t.rd = d; t.rs1 = s1; t.rs2 = s2; t.imm = imm; t.alusrc = src; t.ctrl = op;
        t.regwrite = rw; t.memwrite = mw; t.memread = mr;
        return t;
    endfunction

    function automatic instr_t addi(input logic [4:0] d, input logic [4:0] s1, input logic [31:0] imm);
        return mk(d, s1, 5'd0, imm, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
    endfunction

    function automatic instr_t alur(input logic [2:0] op, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
        return mk(d, s1, s2, 32'd0, 1'b0, op, 1'b1, 1'b0, 1'b0);
    endfunction

    function automatic instr_t sw(input logic [4:0] s2, input logic [31:0] addr);
        return mk(5'd0, 5'd0, s2, addr, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
    endfunction

    function automatic instr_t lw(input logic [4:0] d, input logic [31:0] addr);
        return mk(d, 5'd0, 5'd0, addr, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1);
    endfunction

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 4))
            0:       return 5'd0;
            1:       return 5'd1;
            2:       return 5'd2;
            3:       return 5'd3;
            default: return 5'd10;
        endcase
    endfunction

    function automatic instr_t rand_instr();
        instr_t      t;
        int          kind;
        logic [31:0] maddr;
        kind  = $urandom_range(0, 9);
        maddr = 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
        t.rs1 = pick_reg(); t.rs2 = pick_reg(); t.rd = pick_reg();
        t.imm = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 40));
        t.alusrc = 1'($urandom_range(0, 1));
        t.ctrl = 3'($urandom_range(0, 7));
        t.regwrite = 1'b1; t.memwrite = 1'b0; t.memread = 1'b0;
        if (kind == 6 || kind == 7) begin
            t = lw(pick_reg(), maddr);
        end else if (kind == 8) begin
            t = sw(pick_reg(), maddr);
        end
        return t;
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        edge_cnt = 0; tests = 0; fails = 0; eq_pulses = 0; ready_low_cnt = 0; last_eq = 2;
        for (int i = 0; i < 32; i++) regs[i] = '0;
        exp_a0 = '0; prev_valid = 1'b0; stall_pend = 1'b0; stall_edge = 0; prev_leave = 0;

        // Reset with an instruction presented: nothing may be taken.
        do_reset(2, addi(5'd10, 5'd0, 32'h99));
        idle(5);
        chk("post_rst_a0", a0, 32'd0);

        // Back-to-back dependency through MEM and WB forwarding.
        ready_low_cnt = 0;
        issue(addi(5'd10, 5'd0, 32'd5));
        issue(alur(3'd0, 5'd10, 5'd10, 5'd10));
        idle(5);
        chk("b2b_no_stall", 32'(ready_low_cnt), 32'd0);
        chk("b2b_a0", a0, 32'd10);

        // Load-use: exactly one stall cycle, data forwarded from WB.
        issue(addi(5'd5, 5'd0, 32'h1234));
        issue(sw(5'd5, 32'd8));
        issue(lw(5'd6, 32'd8));
        ready_low_cnt = 0;
        issue(alur(3'd0, 5'd10, 5'd6, 5'd0));
        idle(6);
        chk("lu_stall_cycles", 32'(ready_low_cnt), 32'd1);
        chk("lu_a0", a0, 32'h1234);

        // x0 is hardwired to zero.
        issue(addi(5'd0, 5'd0, 32'd7));
        issue(alur(3'd0, 5'd10, 5'd0, 5'd0));
        idle(5);
        chk("x0_a0", a0, 32'd0);

        // Signed compare.
        issue(addi(5'd1, 5'd0, 32'hFFFF_FFFF));
        issue(addi(5'd2, 5'd0, 32'd1));
        issue(alur(3'd5, 5'd10, 5'd1, 5'd2));
        idle(5);
        chk("slt_a0", a0, 32'd1);

        // Equality flag.
        last_eq = 2;
        issue(alur(3'd1, 5'd3, 5'd1, 5'd1));
        idle(4);
        chk("eq_equal", 32'(last_eq), 32'd1);
        last_eq = 2;
        issue(alur(3'd1, 5'd3, 5'd1, 5'd2));
        idle(4);
        chk("eq_unequal", 32'(last_eq), 32'd0);

        // Throughput: 16 independent adds, no stalls, 16 flag pulses.
        eq_pulses = 0; ready_low_cnt = 0;
        for (int i = 0; i < 16; i++) issue(addi(5'd10, 5'd0, 32'($urandom)));
        idle(5);
        chk("tp_pulses", 32'(eq_pulses), 32'd16);
        chk("tp_no_stall", 32'(ready_low_cnt), 32'd0);

        // Reset mid-flight: in-flight writes and the store are dropped.
        issue(addi(5'd7, 5'd0, 32'h55));
        issue(sw(5'd7, 32'd16));
        issue(addi(5'd8, 5'd0, 32'hAA));
        idle(5);
        issue(addi(5'd10, 5'd0, 32'd1));
        issue(addi(5'd10, 5'd0, 32'd2));
        issue(addi(5'd10, 5'd0, 32'd3));
        issue(sw(5'd8, 32'd16));
        do_reset(1, addi(5'd10, 5'd0, 32'h77));
        idle(4);
        chk("midrst_a0", a0, 32'd0);
        issue(lw(5'd10, 32'd16));
        idle(5);
        chk("midrst_mem", a0, 32'h55);

        // Random streams: initialise a small memory window, then mix ops.
        for (int j = 0; j < 8; j++) issue(sw(5'd0, 32'(j * 4)));
        for (int k = 0; k < 250; k++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            issue(rand_instr());
        end
        idle(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
